// File: rtl/pwm_reg_pkg.sv
// pwm_reg_pkg: register map, response codes and byte-strobe merge shared by the PWM peripheral
package pwm_reg_pkg;
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_PERIOD = 8'h04;
  localparam logic [7:0] REG_DUTY   = 8'h08;
  localparam logic [7:0] REG_COUNT  = 8'h0C;
  localparam logic [7:0] REG_ID     = 8'h10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CTRL_EN_BIT = 0;
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? data[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/pwm_core.sv
// pwm_core: period counter with shadowed period/duty and registered compare output
module pwm_core #(
  parameter logic [31:0] RESET_PERIOD = 32'd1000,
  parameter logic [31:0] RESET_DUTY   = 32'd500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] duty,
  output logic        pwm_out,
  output logic [31:0] count
);
  logic [31:0] count_q, count_d, shadow_period_q, shadow_period_d, shadow_duty_q, shadow_duty_d;
  logic        pwm_q, pwm_d, wrap;
  // a zero period or a disabled core behaves as a permanent wrap so shadows keep tracking the registers
  always_comb begin
    wrap            = !enable || shadow_period_q == '0 || count_q == shadow_period_q - 32'd1;
    shadow_period_d = wrap ? period : shadow_period_q;
    shadow_duty_d   = wrap ? duty : shadow_duty_q;
    count_d         = wrap ? '0 : count_q + 32'd1;
    pwm_d           = enable && shadow_period_q != '0 && count_q < shadow_duty_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q         <= '0;
      shadow_period_q <= RESET_PERIOD;
      shadow_duty_q   <= RESET_DUTY;
      pwm_q           <= 1'b0;
    end else begin
      count_q         <= count_d;
      shadow_period_q <= shadow_period_d;
      shadow_duty_q   <= shadow_duty_d;
      pwm_q           <= pwm_d;
    end
  end
  assign pwm_out = pwm_q;
  assign count   = count_q;
endmodule

// File: rtl/pwm_reg.sv
// pwm_reg: AXI-lite register block driving one PWM output
module pwm_reg
  import pwm_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PERIOD = 32'd1000,
  parameter logic [31:0] RESET_DUTY   = 32'd500,
  parameter logic [31:0] ID_VALUE     = 32'h5057_4d31
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pwm_out,
  input  logic [7:0]  s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [7:0]  s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready
);
  logic        en_q, en_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0] period_q, period_d, duty_q, duty_d, rdata_q, rdata_d, rd_word, count;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [7:0]  wa, ra;
  logic        wr_acc, rd_acc, wr_ok, rd_ok;
  // address decode, register updates and response capture
  always_comb begin
    wa       = s_axil_awaddr & 8'hFC;
    ra       = s_axil_araddr & 8'hFC;
    wr_acc   = s_axil_awvalid && s_axil_wvalid && !bvalid_q;
    rd_acc   = s_axil_arvalid && !rvalid_q;
    wr_ok    = wa == REG_CTRL || wa == REG_PERIOD || wa == REG_DUTY;
    rd_ok    = wr_ok_r(ra);
    en_d     = (wr_acc && wa == REG_CTRL && s_axil_wstrb[CTRL_EN_BIT/8]) ? s_axil_wdata[CTRL_EN_BIT] : en_q;
    period_d = (wr_acc && wa == REG_PERIOD) ? apply_strb(period_q, s_axil_wdata, s_axil_wstrb) : period_q;
    duty_d   = (wr_acc && wa == REG_DUTY) ? apply_strb(duty_q, s_axil_wdata, s_axil_wstrb) : duty_q;
    bvalid_d = wr_acc || (bvalid_q && !s_axil_bready);
    bresp_d  = wr_acc ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
    rd_word  = ra == REG_CTRL   ? 32'(en_q) << CTRL_EN_BIT :
               ra == REG_PERIOD ? period_q :
               ra == REG_DUTY   ? duty_q :
               ra == REG_COUNT  ? count :
               ra == REG_ID     ? ID_VALUE : '0;
    rdata_d  = rd_acc ? rd_word : rdata_q;
    rresp_d  = rd_acc ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
    rvalid_d = rd_acc || (rvalid_q && !s_axil_rready);
  end
  function automatic logic wr_ok_r(input logic [7:0] a);
    return a == REG_CTRL || a == REG_PERIOD || a == REG_DUTY || a == REG_COUNT || a == REG_ID;
  endfunction
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      period_q <= RESET_PERIOD;
      duty_q   <= RESET_DUTY;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      en_q     <= en_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end
  pwm_core #(.RESET_PERIOD(RESET_PERIOD), .RESET_DUTY(RESET_DUTY)) u_core (
    .clk(clk), .rst(rst), .enable(en_q), .period(period_q), .duty(duty_q),
    .pwm_out(pwm_out), .count(count)
  );
  assign s_axil_awready = wr_acc;
  assign s_axil_wready  = wr_acc;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
endmodule

// File: tb/tb_pwm_reg.sv
// tb_pwm_reg: directed and randomized AXI-lite traffic checked every cycle against a behavioural model
module tb_pwm_reg;
  localparam logic [31:0] ID = 32'h5057_4d31;
  logic clk = 0, rst = 1, pwm_out;
  logic [7:0] awaddr = 0, araddr = 0;
  logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rvalid, rready = 0;
  logic [31:0] wdata = 0, rdata;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  int checks = 0, errors = 0;
  bit started = 0;

  pwm_reg dut (
    .clk(clk), .rst(rst), .pwm_out(pwm_out),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file, handshake bookkeeping and a period/phase view of the PWM
  logic [31:0] m_per, m_duty, m_phase, m_sp, m_sd, m_rdata;
  logic m_en, m_pwm, m_bv, m_rv;
  logic [1:0] m_bresp, m_rresp;
  always @(posedge clk) begin : model
    logic wr, rd;
    logic [5:0] wi, ri;
    if (rst) begin
      m_en = 0; m_per = 1000; m_duty = 500; m_phase = 0; m_sp = 1000; m_sd = 500;
      m_pwm = 0; m_bv = 0; m_rv = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
    end else begin
      wr = awvalid && wvalid && !m_bv;
      rd = arvalid && !m_rv;
      wi = awaddr[7:2];
      ri = araddr[7:2];
      if (rd) begin
        case (ri)
          0: m_rdata = {31'b0, m_en};
          1: m_rdata = m_per;
          2: m_rdata = m_duty;
          3: m_rdata = m_phase;
          4: m_rdata = ID;
          default: m_rdata = 0;
        endcase
        m_rresp = (ri <= 4) ? 2'b00 : 2'b10;
      end
      m_rv = rd || (m_rv && !rready);
      m_bv = wr || (m_bv && !bready);
      if (!m_en || m_sp == 0) begin
        m_pwm = 0; m_phase = 0; m_sp = m_per; m_sd = m_duty;
      end else begin
        m_pwm = m_phase < m_sd;
        m_phase = (m_phase + 1) % m_sp;
        if (m_phase == 0) begin m_sp = m_per; m_sd = m_duty; end
      end
      if (wr) begin
        m_bresp = (wi <= 2) ? 2'b00 : 2'b10;
        if (wi == 0 && wstrb[0]) m_en = wdata[0];
        for (int i = 0; i < 4; i++) if (wstrb[i]) begin
          if (wi == 1) m_per[8*i+:8] = wdata[8*i+:8];
          if (wi == 2) m_duty[8*i+:8] = wdata[8*i+:8];
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) if (started) begin
    check("pwm_out", pwm_out, m_pwm);
    check("awready", awready, awvalid && wvalid && !m_bv);
    check("wready", wready, awvalid && wvalid && !m_bv);
    check("bvalid", bvalid, m_bv);
    check("bresp", bresp, m_bresp);
    check("arready", arready, !m_rv);
    check("rvalid", rvalid, m_rv);
    check("rresp", rresp, m_rresp);
    check("rdata", rdata, m_rdata);
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    check("aw_handshake", awready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1; rready = 1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    check("ar_handshake", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    repeat (n) begin @(negedge clk); h += int'(pwm_out); end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int h;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    started = 1;
    check("reset_pwm", pwm_out, 0);
    axi_read(8'h04, d, r); check("rst_period", d, 1000); check("rst_period_resp", r, 0);
    axi_read(8'h08, d, r); check("rst_duty", d, 500); check("rst_duty_resp", r, 0);
    axi_read(8'h10, d, r); check("id", d, ID); check("id_resp", r, 0);
    axi_write(8'h04, 10, 4'hF, r); check("wr_period_resp", r, 0);
    axi_write(8'h08, 3, 4'hF, r);
    axi_write(8'h00, 1, 4'hF, r);
    repeat (5) @(posedge clk);
    count_high(30, h); check("duty3_highs", h, 9);
    axi_read(8'h0C, d, r); check("count_range", d <= 9, 1);
    axi_write(8'h08, 8, 4'hF, r);
    repeat (12) @(posedge clk);
    count_high(30, h); check("duty8_highs", h, 24);
    axi_write(8'h08, 32'h0000_0100, 4'hF, r);
    axi_write(8'h08, 32'hAABB_CC05, 4'b0001, r);
    axi_read(8'h08, d, r); check("strobe_merge", d, 32'h0000_0105);
    axi_write(8'h0C, 5, 4'hF, r); check("ro_count_bresp", r, 2'b10);
    axi_write(8'h20, 5, 4'hF, r); check("unmapped_bresp", r, 2'b10);
    axi_read(8'h20, d, r); check("unmapped_rdata", d, 0); check("unmapped_rresp", r, 2'b10);
    axi_write(8'h08, 20, 4'hF, r);
    repeat (15) @(posedge clk);
    count_high(20, h); check("duty_over_period", h, 20);
    axi_write(8'h04, 0, 4'hF, r);
    repeat (15) @(posedge clk);
    count_high(20, h); check("period_zero", h, 0);
    axi_write(8'h04, 10, 4'hF, r);
    axi_write(8'h08, 3, 4'hF, r);
    repeat (7) @(posedge clk);
    axi_write(8'h00, 0, 4'hF, r);
    check("disable_pwm", pwm_out, 0);
    axi_read(8'h0C, d, r); check("disable_count", d, 0);
    @(posedge clk); #1;
    awaddr = 8'h04; wdata = 12; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    repeat (5) begin
      check("hold_awready", awready, 0);
      check("hold_bvalid", bvalid, 1);
      @(posedge clk); #1;
    end
    bready = 1; awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    bready = 0;
    repeat (800) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      awvalid = $urandom_range(0, 1) == 1;
      wvalid = $urandom_range(0, 3) != 0;
      awaddr = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      wdata = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 12);
      wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      bready = $urandom_range(0, 2) != 0;
      arvalid = $urandom_range(0, 1) == 1;
      araddr = 8'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      rready = $urandom_range(0, 2) != 0;
    end
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_reg.md
Name: pwm_reg

Overview:
AXI-lite slave peripheral that drives one PWM output (LED brightness) from memory-mapped period/duty/control registers. It sits directly downstream of the UART AXI-lite debug bridge, in the same slot as the blinky register block. The host reaches it over the UART bridge: the upper address bits are truncated at the top level and the block decodes an 8-bit byte address.

Parameters:
RESET_PERIOD, 1000, PERIOD register value after reset (clock cycles)
RESET_DUTY, 500, DUTY register value after reset (clock cycles high per period)
ID_VALUE, 32'h5057_4d31, constant returned by the ID register

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
pwm_out  output  1  registered PWM output
s_axil_awaddr  input  8  write byte address
s_axil_awvalid  input  1  write address valid
s_axil_awready  output  1  write address ready
s_axil_wdata  input  32  write data
s_axil_wstrb  input  4  write byte strobes
s_axil_wvalid  input  1  write data valid
s_axil_wready  output  1  write data ready
s_axil_bresp  output  2  write response
s_axil_bvalid  output  1  write response valid
s_axil_bready  input  1  write response ready
s_axil_araddr  input  8  read byte address
s_axil_arvalid  input  1  read address valid
s_axil_arready  output  1  read address ready
s_axil_rdata  output  32  read data
s_axil_rresp  output  2  read response
s_axil_rvalid  output  1  read valid
s_axil_rready  input  1  read ready

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - Outputs: pwm_out=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - Registers: CTRL=0, PERIOD=RESET_PERIOD, DUTY=RESET_DUTY, counter=0, shadows equal the register reset values.
- Register map (byte address; address bits [1:0] ignored):
  - 0x00 CTRL (RW): bit0 enable; other bits read 0.
  - 0x04 PERIOD (RW).
  - 0x08 DUTY (RW).
  - 0x0C COUNT (RO): live counter value.
  - 0x10 ID (RO): ID_VALUE.
- Write channel:
  - awready = wready = awvalid & wvalid & !bvalid. AW and W are accepted together in one cycle, never separately.
  - On acceptance, the register is updated per byte where wstrb[i]=1. bvalid rises the next cycle and holds until bready.
  - bresp=OKAY (2'b00) for RW registers.
  - bresp=SLVERR (2'b10) with no state change for RO registers (0x0C, 0x10) and unmapped addresses.
- Read channel:
  - arready = !rvalid. On acceptance, rdata/rresp are registered and rvalid rises the next cycle; rdata/rresp stay stable until rready.
  - Unmapped address: rdata=0, rresp=SLVERR.
  - The read and write channels operate independently and may complete in the same cycle.
- Read-after-write: a read accepted in the cycle after a write acceptance returns the new value.
- PWM, while enable=1:
  - counter increments each cycle and wraps to 0 when counter == shadow_period-1.
  - pwm_out is registered: pwm_out <= (counter < shadow_duty).
- Shadowing:
  - shadow_period/shadow_duty load from PERIOD/DUTY on the wrap cycle, and on every cycle while enable=0.
  - There is no mid-period glitch.
- Boundary cases:
  - shadow_period=0: counter holds 0 and pwm_out=0.
  - DUTY >= PERIOD: pwm_out constantly 1.
  - DUTY=0: constantly 0.
  - PERIOD=1 with DUTY>=1: constantly 1.
- Enable cleared: counter <= 0 and pwm_out <= 0 on the next edge.
- Enable set: counting starts from 0 with freshly loaded shadows; the first high cycle appears at pwm_out 1 cycle after enable is seen.
- COUNT read: returns the counter value sampled on the AR acceptance cycle.
- Reset mid-transaction: pending bvalid/rvalid drop and all registers return to reset values. The master is required to restart.
- Counter and compares are 32-bit unsigned; no overflow is possible since counter < period.

Decomposition:
- Shared package pwm_reg_pkg holds:
  - register offset localparams: REG_CTRL, REG_PERIOD, REG_DUTY, REG_COUNT, REG_ID;
  - response codes RESP_OKAY and RESP_SLVERR;
  - CTRL bit index CTRL_EN_BIT.
- One natural sub-module, pwm_core: counter, shadow registers and output compare. Inputs are enable/period/duty; outputs are pwm_out/count.
- The AXI-lite decode stays in pwm_reg.

Test Plan:
- Reset, then read 0x04, 0x08, 0x10 -> 1000, 500, 32'h5057_4d31, all OKAY; pwm_out=0.
- Write PERIOD=10, DUTY=3, CTRL=1 -> pwm_out repeats 3 cycles high / 7 low; COUNT reads within 0..9.
- While running PERIOD=10 DUTY=3, write DUTY=8 mid-period -> the current period keeps 3 high; the next period onward is 8 high / 2 low.
- Write DUTY with wstrb=4'b0001, data 32'hAABBCC05, onto DUTY=32'h0000_0100 -> reads back 32'h0000_0105.
- Write 0x0C, write 0x20, read 0x20 -> bresp=2'b10, bresp=2'b10, rresp=2'b10 with rdata=0; COUNT unaffected.
- Boundaries:
  - PERIOD=0 -> pwm_out stays 0.
  - DUTY=20 with PERIOD=10 -> pwm_out stays 1.
  - Clear CTRL -> next cycle pwm_out=0, COUNT=0.
  - Hold bready=0 for 5 cycles -> awready stays 0 and bvalid stays 1.
